// File: rtl/sequence_burst_ctrl_if.sv
// Handshake and data bundle between the burst controller, its request source,
// the 8-bit sequence generator and the downstream consumer.
interface sequence_burst_ctrl_if #(
    parameter int unsigned LEN_W  = 4,
    parameter int unsigned SKIP_W = 3
) ();
    logic              start;
    logic [LEN_W-1:0]  len;
    logic [SKIP_W-1:0] skip;
    logic              abort;
    logic              gen_enable;
    logic [7:0]        gen_data;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    // master: the burst controller itself
    modport master (
        input  start, len, skip, abort, gen_data, out_ready,
        output gen_enable, out_data, out_valid, busy, done
    );

    // slave: the environment around the controller
    modport slave (
        output start, len, skip, abort, gen_data, out_ready,
        input  gen_enable, out_data, out_valid, busy, done
    );
endinterface

// File: rtl/sequence_burst_ctrl.sv
// Burst controller: discards `skip` generator words, then streams `len` words
// downstream under a valid/ready handshake, pulsing done on normal completion.
module sequence_burst_ctrl #(
    parameter int unsigned LEN_W  = 4,
    parameter int unsigned SKIP_W = 3
) (
    input logic                  clock,
    input logic                  reset_n,
    sequence_burst_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        StIdle,
        StSkip,
        StStream,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
    logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;

    logic              gen_enable;
    logic              out_valid;
    logic              done;
    logic              accept;
    logic [LEN_W:0]    words_next;

    // One bit wider so len = 2^LEN_W-1 compares without wrapping.
    assign words_next = {1'b0, word_cnt_q} + {{LEN_W{1'b0}}, 1'b1};
    assign accept     = out_valid & bus.out_ready;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            len_q      <= '0;
            skip_cnt_q <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            skip_cnt_q <= skip_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        skip_cnt_d = skip_cnt_q;
        word_cnt_d = word_cnt_q;
        gen_enable = 1'b0;
        out_valid  = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    len_d      = bus.len;
                    skip_cnt_d = bus.skip;
                    word_cnt_d = '0;
                    if (bus.skip != '0) begin
                        state_d = StSkip;
                    end else if (bus.len != '0) begin
                        state_d = StStream;
                    end else begin
                        state_d = StDone;
                    end
                end
            end

            StSkip: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else begin
                    gen_enable = 1'b1;
                    skip_cnt_d = skip_cnt_q - SKIP_W'(1);
                    if (skip_cnt_q == SKIP_W'(1)) begin
                        state_d = (len_q != '0) ? StStream : StDone;
                    end
                end
            end

            StStream: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else begin
                    out_valid  = 1'b1;
                    gen_enable = bus.out_ready;
                    if (bus.out_ready) begin
                        word_cnt_d = words_next[LEN_W-1:0];
                        if (words_next == {1'b0, len_q}) begin
                            state_d = StDone;
                        end
                    end
                end
            end

            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    assign bus.gen_enable = gen_enable;
    assign bus.out_valid  = out_valid;
    assign bus.out_data   = out_valid ? bus.gen_data : 8'h00;
    assign bus.done       = done;
    assign bus.busy       = (state_q != StIdle);

    logic unused_accept;
    assign unused_accept = accept;

endmodule
